// File: rtl/blinker_pattern_seq_if.sv
// Pattern load channel: valid/ready handshake carrying pattern, hold and repeat fields.
interface blinker_pattern_seq_if #(
  parameter int IDX_W  = 4,
  parameter int HOLD_W = 4,
  parameter int REP_W  = 4
);
  localparam int PAT_W = 1 << IDX_W;

  logic              pat_valid_i;
  logic              pat_ready_o;
  logic [PAT_W-1:0]  pat_data_i;
  logic [HOLD_W-1:0] hold_i;
  logic [REP_W-1:0]  reps_i;

  modport master (
    output pat_valid_i, pat_data_i, hold_i, reps_i,
    input  pat_ready_o
  );

  modport slave (
    input  pat_valid_i, pat_data_i, hold_i, reps_i,
    output pat_ready_o
  );
endinterface

// File: rtl/blinker_pattern_seq.sv
// Blink pattern sequencer: plays a latched pattern one bit per (hold+1) ticks, (reps+1) times.
// state | meaning
// IDLE  | waiting for a pattern load
// RUN   | playing the pattern, advancing on tick_i
// DONE  | one-cycle completion pulse, then back to IDLE
module blinker_pattern_seq #(
  parameter int IDX_W  = 4,
  parameter int HOLD_W = 4,
  parameter int REP_W  = 4
) (
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic                 tick_i,
  input  logic                 abort_i,
  blinker_pattern_seq_if.slave pat_if,
  output logic                 led_o,
  output logic                 busy_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 done_o
);
  localparam int PAT_W = 1 << IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      hold_q     <= '0;
      reps_q     <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      hold_q     <= hold_d;
      reps_q     <= reps_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    hold_d     = hold_q;
    reps_d     = reps_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    case (state_q)
      IDLE: begin
        if (pat_if.pat_valid_i) begin
          pat_d      = pat_if.pat_data_i;
          hold_d     = pat_if.hold_i;
          reps_d     = pat_if.reps_i;
          idx_d      = '0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // abort takes priority over a tick landing in the same cycle
        if (abort_i) begin
          state_d    = IDLE;
          idx_d      = '0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (tick_i) begin
          if (hold_cnt_q != hold_q) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            hold_cnt_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d = idx_q + IDX_W'(1);
            end else if (rep_cnt_q != reps_q) begin
              idx_d     = '0;
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        idx_d      = '0;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pat_if.pat_ready_o = (state_q == IDLE);
  assign busy_o             = (state_q == RUN);
  assign done_o             = (state_q == DONE);
  assign led_o              = (state_q == RUN) && pat_q[idx_q];
  assign idx_o              = idx_q;
endmodule

// File: tb/tb_blinker_pattern_seq.sv
// Bench for blinker_pattern_seq: directed and random playbacks against a tick-count reference model.
module tb_blinker_pattern_seq;
  logic       system1000 = 1'b0;
  logic       system1000_rst;
  logic       tick_i;
  logic       abort_i;
  logic       led_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] idx_o;

  int n_total = 0;
  int n_pass  = 0;

  blinker_pattern_seq_if pat_if ();

  blinker_pattern_seq dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .tick_i         (tick_i),
    .abort_i        (abort_i),
    .pat_if         (pat_if),
    .led_o          (led_o),
    .busy_o         (busy_o),
    .idx_o          (idx_o),
    .done_o         (done_o)
  );

  always #5 system1000 = ~system1000;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp, input logic [7:0] mask);
    n_total++;
    assert ((obs & mask) === (exp & mask)) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs & mask, exp & mask);
  endtask

  function automatic logic [7:0] obs_v();
    return {led_o, busy_o, done_o, pat_if.pat_ready_o, idx_o};
  endfunction

  function automatic logic [7:0] mk(input bit led, input bit busy, input bit done, input bit rdy, input int idx);
    return {led, busy, done, rdy, 4'(idx)};
  endfunction

  task automatic cyc();
    @(posedge system1000);
    #1;
  endtask

  task automatic load(input logic [15:0] pat, input int h, input int r);
    pat_if.pat_valid_i = 1'b1;
    pat_if.pat_data_i  = pat;
    pat_if.hold_i      = 4'(h);
    pat_if.reps_i      = 4'(r);
    cyc();
    pat_if.pat_valid_i = 1'b0;
  endtask

  // Called just after the accepting edge. Expected outputs come from the tick count alone:
  // bit index = (ticks / (h+1)) mod 16, playback ends after 16*(h+1)*(r+1) ticks.
  // tick_mode: 0 continuous, k>0 one tick every k cycles, -1 random.
  task automatic play(input string name, input logic [15:0] pat, input int h, input int r,
                      input int tick_mode, input int abort_idx, input int rst_idx);
    int  ticks;
    int  total;
    int  cyc_n;
    int  exp_idx;
    bit  t;
    bit  stop;
    ticks = 0;
    total = 16 * (h + 1) * (r + 1);
    cyc_n = 0;
    stop  = 1'b0;
    while (!stop) begin
      exp_idx = (ticks / (h + 1)) % 16;
      chk({name, " run"}, obs_v(), mk(pat[exp_idx], 1'b1, 1'b0, 1'b0, exp_idx), 8'hFF);
      if (tick_mode == 0)     t = 1'b1;
      else if (tick_mode > 0) t = ((cyc_n % tick_mode) == tick_mode - 1);
      else                    t = ($urandom_range(0, 2) == 0);
      if (exp_idx == abort_idx) begin
        t       = 1'b1;
        abort_i = 1'b1;
      end
      if (exp_idx == rst_idx) system1000_rst = 1'b1;
      tick_i = t;
      cyc();
      tick_i = 1'b0;
      cyc_n++;
      if (abort_i || system1000_rst) begin
        abort_i        = 1'b0;
        system1000_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          chk({name, " stopped"}, obs_v(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0), 8'hFF);
          cyc();
        end
        return;
      end
      if (t) ticks++;
      if (ticks == total) begin
        chk({name, " done"}, obs_v(), mk(1'b0, 1'b0, 1'b1, 1'b0, 0), 8'hF0);
        cyc();
        chk({name, " idle"}, obs_v(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0), 8'hF0);
        stop = 1'b1;
      end else if (cyc_n > 20000) begin
        chk({name, " cycle budget"}, obs_v(), mk(1'b0, 1'b0, 1'b1, 1'b0, 0), 8'hF0);
        stop = 1'b1;
      end
    end
  endtask

  initial begin
    logic [15:0] rp;
    system1000_rst     = 1'b1;
    tick_i             = 1'b0;
    abort_i            = 1'b0;
    pat_if.pat_valid_i = 1'b0;
    pat_if.pat_data_i  = '0;
    pat_if.hold_i      = '0;
    pat_if.reps_i      = '0;
    cyc();
    chk("reset held", obs_v(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0), 8'hFF);
    system1000_rst = 1'b0;
    cyc();
    chk("after reset", obs_v(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0), 8'hFF);

    load(16'h0005, 0, 0);
    play("p0005", 16'h0005, 0, 0, 0, 99, 99);

    load(16'h0001, 2, 0);
    play("p0001_h2", 16'h0001, 2, 0, 4, 99, 99);

    load(16'h8001, 0, 2);
    play("p8001_r2", 16'h8001, 0, 2, 0, 99, 99);

    // load held during playback must not disturb it and is taken once idle
    load(16'h00F0, 1, 0);
    pat_if.pat_valid_i = 1'b1;
    pat_if.pat_data_i  = 16'hFFFF;
    pat_if.hold_i      = 4'd0;
    pat_if.reps_i      = 4'd0;
    play("busy_load", 16'h00F0, 1, 0, -1, 99, 99);
    cyc();
    pat_if.pat_valid_i = 1'b0;
    play("held_ffff", 16'hFFFF, 0, 0, 0, 99, 99);

    load(16'h0A35, 1, 1);
    play("abort5", 16'h0A35, 1, 1, 2, 5, 99);

    abort_i = 1'b1;
    load(16'hAAAA, 0, 0);
    abort_i = 1'b0;
    play("idle_abort_load", 16'hAAAA, 0, 0, 0, 99, 99);

    load(16'h0FF0, 0, 0);
    play("rst7", 16'h0FF0, 0, 0, 0, 99, 7);
    load(16'h0003, 0, 0);
    play("after_rst", 16'h0003, 0, 0, 0, 99, 99);

    for (int k = 0; k < 6; k++) begin
      int h;
      int r;
      rp = 16'($urandom);
      h  = $urandom_range(0, 3);
      r  = $urandom_range(0, 2);
      load(rp, h, r);
      play("random", rp, h, r, -1, 99, 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
